// File: rtl/ucode_pkg.sv
// Shared definitions for the micro-op sequencer: macro/micro-op opcodes,
// instruction field positions, FSM state encoding and the micro-op layout.
package ucode_pkg;

   localparam int unsigned OPC_W  = 7;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned OFF_W  = 16;
   localparam int unsigned INSN_W = 32;

   localparam logic [OPC_W-1:0] OP_LDM  = 7'b0101000;
   localparam logic [OPC_W-1:0] OP_STM  = 7'b0101001;
   localparam logic [OPC_W-1:0] UOP_LDR = 7'b0100000;
   localparam logic [OPC_W-1:0] UOP_STR = 7'b0100001;

   // Incoming instruction field positions
   localparam int unsigned IN_OPC_MSB  = 31;
   localparam int unsigned IN_OPC_LSB  = 25;
   localparam int unsigned IN_BASE_MSB = 19;
   localparam int unsigned IN_BASE_LSB = 16;
   localparam int unsigned IN_RL_MSB   = 15;
   localparam int unsigned IN_RL_LSB   = 0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_SKIP   = 2'd2
   } state_t;

   // Expanded micro-op: [31:25] opc, [24:21] rd, [20:17] base, [16] 0, [15:0] offset
   typedef struct packed {
      logic [OPC_W-1:0] opc;
      logic [IDX_W-1:0] rd;
      logic [IDX_W-1:0] base;
      logic             zero;
      logic [OFF_W-1:0] off;
   } uop_t;

   function automatic logic is_macro(input logic [OPC_W-1:0] opc);
      return (opc == OP_LDM) || (opc == OP_STM);
   endfunction

endpackage

// File: rtl/ucode_pri_enc.sv
// Lowest-set-bit encoder.
//   vec   : input mask
//   idx   : index of the lowest set bit (0 when vec is empty)
//   found : vec has at least one bit set
//   multi : vec has more than one bit set
module ucode_pri_enc #(
   parameter int unsigned NREGS = 16
) (
   input  logic [NREGS-1:0] vec,
   output logic [3:0]       idx,
   output logic             found,
   output logic             multi
);

   // Scan downward so the lowest set bit is the last to write idx
   always_comb begin
      idx = '0;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (vec[i]) idx = 4'(i);
      end
   end

   assign found = |vec;
   // Clearing the lowest set bit leaves something only if two or more were set
   assign multi = |(vec & (vec - NREGS'(1)));

endmodule

// File: rtl/ucode_seq.sv
// Micro-code sequencer: passes ordinary instructions through and expands
// LDM/STM register-list macros into one LDR/STR micro-op per listed register.
//   clk, rst        : clock, asynchronous active-low reset
//   instr_in        : instruction from fetch, qualified by in_valid
//   flush           : synchronous abort, highest priority
//   control         : combinational fetch-freeze request
//   uop_out/valid   : registered micro-op to decode
//   busy            : sequencer is not idle
module ucode_seq
   import ucode_pkg::*;
#(
   parameter int unsigned STRIDE = 4,
   parameter int unsigned NREGS  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INSN_W-1:0] instr_in,
   input  logic              in_valid,
   input  logic              flush,
   output logic              control,
   output logic [INSN_W-1:0] uop_out,
   output logic              uop_valid,
   output logic              busy
);

   localparam int unsigned KW = $clog2(NREGS + 1);

   state_t            state, state_nxt;
   logic [NREGS-1:0]  mask, mask_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [IDX_W-1:0]  base_q, base_nxt;
   logic              stm_q, stm_nxt;
   logic [INSN_W-1:0] uop_nxt;
   logic              uop_valid_nxt;

   logic [IDX_W-1:0]  idx;
   logic              found, multi;
   logic [OPC_W-1:0]  in_opc;
   logic [15:0]       in_rl;
   logic              in_macro;
   logic              start;
   logic [OFF_W-1:0]  off;
   uop_t              emit;

   assign in_opc   = instr_in[IN_OPC_MSB:IN_OPC_LSB];
   assign in_rl    = instr_in[IN_RL_MSB:IN_RL_LSB];
   assign in_macro = is_macro(in_opc);
   // An empty register list is treated as a plain bubble, never an expansion
   assign start    = in_valid && in_macro && (in_rl != '0);
   assign off      = 16'(k) * 16'(STRIDE);
   assign busy     = (state != S_IDLE);

   ucode_pri_enc #(.NREGS(NREGS)) u_pri_enc (
      .vec   (mask),
      .idx   (idx),
      .found (found),
      .multi (multi)
   );

   // Micro-op for the lowest remaining register
   always_comb begin
      emit      = '0;
      emit.opc  = stm_q ? UOP_STR : UOP_LDR;
      emit.rd   = idx;
      emit.base = base_q;
      emit.zero = 1'b0;
      emit.off  = off;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (start) state_nxt = S_EXPAND;
            S_EXPAND: if (!found || !multi) state_nxt = S_SKIP;
            S_SKIP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      mask_nxt      = mask;
      k_nxt         = k;
      base_nxt      = base_q;
      stm_nxt       = stm_q;
      uop_nxt       = uop_out;
      uop_valid_nxt = 1'b0;
      control       = 1'b0;
      if (flush) begin
         mask_nxt = '0;
         k_nxt    = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && !in_macro) begin
                  uop_nxt       = instr_in;
                  uop_valid_nxt = 1'b1;
               end else if (start) begin
                  mask_nxt = NREGS'(in_rl);
                  k_nxt    = '0;
                  base_nxt = instr_in[IN_BASE_MSB:IN_BASE_LSB];
                  stm_nxt  = (in_opc == OP_STM);
                  control  = 1'b1;
               end
            end
            S_EXPAND: begin
               if (found) begin
                  uop_nxt       = emit;
                  uop_valid_nxt = 1'b1;
                  mask_nxt      = mask & ~(NREGS'(1) << idx);
                  k_nxt         = k + KW'(1);
                  // Drop the freeze on the last micro-op so fetch advances
                  control       = multi;
               end
            end
            default: ;
         endcase
      end
      // Freeze request must vanish the moment reset asserts
      if (!rst) control = 1'b0;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uop_out   <= '0;
         uop_valid <= 1'b0;
         mask      <= '0;
         k         <= '0;
         base_q    <= '0;
         stm_q     <= 1'b0;
      end else begin
         uop_out   <= uop_nxt;
         uop_valid <= uop_valid_nxt;
         mask      <= mask_nxt;
         k         <= k_nxt;
         base_q    <= base_nxt;
         stm_q     <= stm_nxt;
      end
   end

endmodule
